// File: rtl/backscatter_modulator.sv
// backscatter_modulator
// Tag-side transmit stage: after a guard delay following a rising edge of
// `sending`, drives the RF switch with a square-wave subcarrier whose phase
// is inverted per symbol by the frame data (MSB first).
// Build option: PRBS_PAYLOAD_EN -- frame bits come from an internal PRBS7
// (x^7+x^6+1, seed 7'h7F) instead of the latched `payload` port.
//
// state | meaning
// IDLE  | switch at rest, waiting for a rising edge of sending
// ARM   | guard delay after frame start
// SEND  | modulating the subcarrier with the frame bits
// HOLD  | frame complete, waiting for sending to drop
module backscatter_modulator #(
  parameter int HALF_PERIOD  = 4,
  parameter int SYMBOL_CLKS  = 40,
  parameter int START_DELAY  = 1000,
  parameter int PAYLOAD_BITS = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sending,
  input  logic [PAYLOAD_BITS-1:0] payload,
  output logic                    rf_sw,
  output logic                    active,
  output logic                    done
);

  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int SW = (SYMBOL_CLKS > 1) ? $clog2(SYMBOL_CLKS) : 1;
  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [6:0] BITS_END = 7'(PAYLOAD_BITS);

  typedef enum logic [1:0] {IDLE, ARM, SEND, HOLD} state_t;

  state_t        state_q, state_d;
  logic          sending_q;
  logic [DW-1:0] dly_q;
  logic [HW-1:0] sub_q;
  logic [SW-1:0] sym_q;
  logic [6:0]    bit_q;
  logic          sq_q;
  logic          rf_sw_q, rf_sw_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          cur_bit;

  wire start     = sending && !sending_q;
  wire dly_end   = (dly_q == DW'(START_DELAY - 1));
  wire sub_wrap  = (sub_q == HW'(HALF_PERIOD - 1));
  wire sym_wrap  = (sym_q == SW'(SYMBOL_CLKS - 1));
  wire frame_end = (bit_q == BITS_END);
  wire advance   = (state_q == SEND) && sending && !frame_end;

`ifdef PRBS_PAYLOAD_EN
  logic [6:0] prbs_q;
  logic       unused_payload;
  assign unused_payload = ^payload;
  assign cur_bit = prbs_q[6];

  // PRBS7 steps once per completed symbol and free-runs across frames
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prbs_q <= 7'h7F;
    else if (advance && sym_wrap) prbs_q <= {prbs_q[5:0], prbs_q[6] ^ prbs_q[5]};
  end
`else
  logic [PAYLOAD_BITS-1:0] sr_q;
  assign cur_bit = sr_q[PAYLOAD_BITS-1];

  // Payload latched at frame start, shifted MSB-first once per symbol
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sr_q <= '0;
    else if (state_q == IDLE && start) sr_q <= payload;
    else if (advance && sym_wrap) sr_q <= sr_q << 1;
  end
`endif

  // State register and edge-detect flop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sending_q <= sending;
    end
  end

  // Next-state logic; a low sending aborts ARM and SEND
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = ARM;
      ARM: begin
        if (!sending) state_d = IDLE;
        else if (dly_end) state_d = SEND;
      end
      SEND: begin
        if (!sending) state_d = IDLE;
        else if (frame_end) state_d = HOLD;
      end
      HOLD: if (!sending) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    rf_sw_d  = 1'b0;
    active_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: active_d = start;
      ARM:  active_d = sending;
      SEND: begin
        if (sending) begin
          if (frame_end) begin
            done_d = 1'b1;
          end else begin
            active_d = 1'b1;
            rf_sw_d  = sq_q ^ cur_bit;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_sw_q  <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rf_sw_q  <= rf_sw_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  // Guard delay, subcarrier, symbol and bit counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dly_q <= '0;
      sub_q <= '0;
      sym_q <= '0;
      bit_q <= '0;
      sq_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start) dly_q <= '0;
    end else if (state_q == ARM) begin
      if (dly_end) begin
        sub_q <= '0;
        sym_q <= '0;
        bit_q <= '0;
        sq_q  <= 1'b0;
      end else begin
        dly_q <= dly_q + DW'(1);
      end
    end else if (advance) begin
      if (sub_wrap) begin
        sub_q <= '0;
        sq_q  <= ~sq_q;
      end else begin
        sub_q <= sub_q + HW'(1);
      end
      if (sym_wrap) begin
        sym_q <= '0;
        bit_q <= bit_q + 7'd1;
      end else begin
        sym_q <= sym_q + SW'(1);
      end
    end
  end

  assign rf_sw  = rf_sw_q;
  assign active = active_q;
  assign done   = done_q;

endmodule

// File: tb/tb_backscatter_modulator.sv
// Self-checking bench for backscatter_modulator (small parameters), plus a
// default-parameter instance held idle to confirm the switch never moves.
module tb_backscatter_modulator;

  localparam int HP = 2;
  localparam int SC = 8;
  localparam int SD = 10;
`ifdef PRBS_PAYLOAD_EN
  localparam int PB = 7;
`else
  localparam int PB = 4;
`endif
  localparam int K = SD + PB * SC + 1 + 100;

  logic          clock = 1'b0;
  logic          reset;
  logic          sending;
  logic [PB-1:0] payload;
  logic          rf_sw, active, done;

  logic          sending0 = 1'b0;
  logic [31:0]   payload0 = 32'hFFFF_FFFF;
  logic          rf_sw0, active0, done0;

  always #5 clock = ~clock;

  backscatter_modulator #(
    .HALF_PERIOD(HP), .SYMBOL_CLKS(SC), .START_DELAY(SD), .PAYLOAD_BITS(PB)
  ) dut (
    .clock(clock), .reset(reset), .sending(sending), .payload(payload),
    .rf_sw(rf_sw), .active(active), .done(done)
  );

  backscatter_modulator dut0 (
    .clock(clock), .reset(reset), .sending(sending0), .payload(payload0),
    .rf_sw(rf_sw0), .active(active0), .done(done0)
  );

  typedef struct {
    logic rf;
    logic act;
    logic dn;
  } exp_t;

  typedef struct {
    logic [PB-1:0] pl;
    int            abort_k;
    bit            chg;
  } vec_t;

  exp_t q[$];
  vec_t vecs[6];
  int   nvec;
  int   tests = 0;
  int   fails = 0;
  int   bad0  = 0;

  always @(negedge clock) if (rf_sw0 || active0 || done0) bad0++;

  task automatic check(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic push(input logic rf, input logic act, input logic dn);
    exp_t e;
    e.rf = rf; e.act = act; e.dn = dn;
    q.push_back(e);
  endtask

  task automatic step_check(input string tag);
    exp_t e;
    @(posedge clock);
    #1;
    e = q.pop_front();
    check({tag, ".rf_sw"},  rf_sw,  e.rf);
    check({tag, ".active"}, active, e.act);
    check({tag, ".done"},   done,   e.dn);
  endtask

  // Expected outputs after edge E+k of an uninterrupted frame
  function automatic exp_t expect_at(input int k, input logic [PB-1:0] bits);
    exp_t e;
    int j;
    e.rf = 1'b0; e.act = 1'b0; e.dn = 1'b0;
    if (k <= SD) begin
      e.act = 1'b1;
    end else if (k <= SD + PB * SC) begin
      j = k - SD - 1;
      e.act = 1'b1;
      e.rf  = bits[PB - 1 - j / SC] ^ ((j % (2 * HP)) >= HP);
    end else if (k == SD + PB * SC + 1) begin
      e.dn = 1'b1;
    end
    return e;
  endfunction

  initial begin
    logic [PB-1:0] bits;
    logic [6:0]    lfsr;
    exp_t          e;

`ifdef PRBS_PAYLOAD_EN
    vecs[0] = '{pl: '0, abort_k: -1, chg: 1'b0};
    vecs[1] = '{pl: '1, abort_k: -1, chg: 1'b0};
    nvec = 2;
`else
    vecs[0] = '{pl: 4'b1010, abort_k: -1, chg: 1'b0};
    vecs[1] = '{pl: 4'b1010, abort_k: SD + 1 + 2 * SC + 3, chg: 1'b0};
    vecs[2] = '{pl: 4'b0110, abort_k: -1, chg: 1'b0};
    vecs[3] = '{pl: 4'b1101, abort_k: -1, chg: 1'b1};
    vecs[4] = '{pl: 4'b0011, abort_k: 5, chg: 1'b0};
    vecs[5] = '{pl: 4'b1001, abort_k: -1, chg: 1'b0};
    nvec = 6;
`endif
    lfsr = 7'h7F;

    reset = 1'b0; sending = 1'b0; payload = '0;
    #1;
    check("reset.rf_sw",  rf_sw,  1'b0);
    check("reset.active", active, 1'b0);
    check("reset.done",   done,   1'b0);
    @(negedge clock);
    reset = 1'b1;

    for (int v = 0; v < nvec; v++) begin
      sending = 1'b0;
      payload = vecs[v].pl;
      repeat (2) begin
        push(1'b0, 1'b0, 1'b0);
        step_check($sformatf("v%0d.idle", v));
      end
`ifdef PRBS_PAYLOAD_EN
      for (int i = 0; i < PB; i++) begin
        bits[PB - 1 - i] = lfsr[6];
        lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      end
`else
      bits = vecs[v].pl;
`endif
      sending = 1'b1;
      for (int k = 0; k < K; k++) begin
        if (vecs[v].chg && k == 3) payload = ~payload;
        if (vecs[v].abort_k >= 0 && k == vecs[v].abort_k) sending = 1'b0;
        if (vecs[v].abort_k >= 0 && k >= vecs[v].abort_k) begin
          e.rf = 1'b0; e.act = 1'b0; e.dn = 1'b0;
        end else begin
          e = expect_at(k, bits);
        end
        push(e.rf, e.act, e.dn);
        step_check($sformatf("v%0d.k%0d", v, k));
      end
    end

    // Asynchronous reset in the middle of a frame
    sending = 1'b0;
    push(1'b0, 1'b0, 1'b0);
    step_check("rst.pre");
    sending = 1'b1;
    repeat (SD + 5) @(posedge clock);
    #1;
    check("rst.active_before", active, 1'b1);
    #2;
    reset = 1'b0;
    sending = 1'b0;
    #1;
    check("rst.rf_sw",  rf_sw,  1'b0);
    check("rst.active", active, 1'b0);
    check("rst.done",   done,   1'b0);
    @(negedge clock);
    reset = 1'b1;
    repeat (30) begin
      push(1'b0, 1'b0, 1'b0);
      step_check("rst.after");
    end

    repeat (5000) @(posedge clock);
    tests++;
    if (bad0 != 0) begin
      fails++;
      $display("FAIL default_idle: got %0d active cycles expected 0", bad0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
